arb4_ctrl: RTL
==============

# arb4_ctrl

Four-requester arbiter that shares one downstream resource (bus port, shared datapath unit) between four clients. Arbitration is built around a 4-to-2 priority encoder: highest active index wins, with an optional round-robin rotation in front of it. Each grant is held for a whole transaction and can be cut short by a hold-limit timeout. The block sits between the requesting masters and the shared resource's select/mux logic.

## Interface
- MODE, 0, arbitration policy: 0 = fixed priority (req[3] highest, req[0] lowest), 1 = round-robin
- MAX_HOLD, 16, maximum consecutive grant cycles per grant (1..255); 0 = unlimited
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req  in  4  request lines, level-sensitive, one per client
- gnt  out  4  one-hot grant, registered
- gnt_id  out  2  index of granted client, valid when gnt_valid=1
- gnt_valid  out  1  high while any grant is held
- timeout  out  1  one-cycle pulse when a grant is forcibly released by MAX_HOLD

## Operation
- Reset: gnt=4'b0000, gnt_id=2'b00, gnt_valid=0, timeout=0, state=IDLE, rotation pointer ptr=2'd0, hold counter=0. Reset asserted mid-grant drops gnt at that edge.
- States: IDLE, GRANT.
- IDLE: if req!=0 at an edge, pick winner, load gnt/gnt_id, set gnt_valid, clear hold counter, go GRANT. If req==0, stay IDLE with outputs low.
- Winner selection:
  - MODE=0: encoder on req directly.
  - MODE=1: rotate r[i]=req[(i+ptr) mod 4], encode r, winner=(enc+ptr) mod 4. Client ptr is lowest priority and client ptr-1 is highest. ptr=0 after reset gives the same order as fixed priority.
- GRANT: each edge, hold counter increments (8-bit, saturating).
  - Release if req[gnt_id]==0, or if MAX_HOLD!=0 and counter==MAX_HOLD-1.
  - On release: gnt=0, gnt_valid=0, go IDLE; in MODE=1, ptr←gnt_id.
  - Timeout release also sets timeout=1 for that one following cycle. Owner-drop takes precedence, so no timeout if both occur at once.
- Changes on non-owner req lines during GRANT are ignored.
- A timed-out client still requesting re-enters arbitration normally. In MODE=0 it can win again immediately.
- gnt is always one-hot or zero. gnt_id holds its last value while gnt_valid=0.

## Timing
- Request-to-grant latency: 1 edge. req sampled high in IDLE at edge N gives gnt high in cycle N+1.
- Grant length: at least 1 cycle. With MAX_HOLD=M it is at most M cycles.
- Turnaround: mandatory one-cycle gap with gnt=0 between consecutive grants. The next winner is sampled at the end of the gap cycle.
- Release: owner req low at edge E gives gnt low after E.
- timeout is coincident with the gap cycle.
- All outputs are registers; no combinational path from req to outputs.

## Structure
- Package arb_pkg: state encoding (ST_IDLE, ST_GRANT), MODE_FIXED=0, MODE_RR=1, hold-counter width constant (8).
- Sub-module prio_enc4 (combinational): 4-bit in, 2-bit index out, valid out, highest index wins. Instantiated once on the rotated vector.
- Top module arb4_ctrl: FSM, ptr register, hold counter, output registers.

## Test plan
- Reset: rst=1 for 2 cycles with req=4'b1111 -> gnt=0, gnt_valid=0, timeout=0 throughout. First grant is gnt=4'b1000 one cycle after rst falls.
- Fixed priority, MODE=0: req=4'b0101 -> gnt=4'b0100, gnt_id=2. Drop req[2] -> one gap cycle with gnt=0, then gnt=4'b0001, gnt_id=0.
- Round-robin, MODE=1, MAX_HOLD=3, req=4'b1111 held:
  - grant order 3,2,1,0,3;
  - each grant lasts 3 cycles;
  - timeout=1 in each gap cycle.
- Short transaction: req=4'b0010 for one cycle only -> gnt=4'b0010 for exactly one cycle, no timeout. Raising req[3] during a req[1] grant does not preempt it.
- Unlimited hold, MAX_HOLD=0: req[1] held 300 cycles -> gnt=4'b0010 continuous for 300 cycles, timeout never asserts, no counter-wrap release.
- Reset mid-grant: assert rst while gnt=4'b1000 -> gnt=0 the next cycle. After release, MODE=1 ptr=0 gives order 3 first.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and helpers for the four-client arbiter.
// Holds the FSM encoding, policy codes and hold-counter width.
package arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;
  localparam int HOLD_W     = 8;

  function automatic logic [3:0] rot4(
    input logic [3:0] v,
    input logic [1:0] sh
  );
    logic [3:0] r;
    for (int i = 0; i < 4; i++) begin
      r[i] = v[2'(i) + sh];
    end
    return r;
  endfunction

  function automatic logic [3:0] dec4(
    input logic [1:0] id
  );
    return 4'b0001 << id;
  endfunction

endpackage

// File: rtl/arb4_ctrl_enc.sv
// Combinational 4-to-2 priority encoder.
// The highest set index wins; valid_o flags any input set.
module prio_enc4 (
  input  logic [3:0] in_i,
  output logic [1:0] idx_o,
  output logic       valid_o
);

  always_comb begin
    idx_o   = 2'd0;
    valid_o = 1'b1;
    priority case (1'b1)
      in_i[3]: idx_o = 2'd3;
      in_i[2]: idx_o = 2'd2;
      in_i[1]: idx_o = 2'd1;
      in_i[0]: idx_o = 2'd0;
      default: valid_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/arb4_ctrl.sv
// Four-requester arbiter, fixed or round-robin,
// with whole-transaction grants and a hold-limit timeout.
module arb4_ctrl
  import arb_pkg::*;
#(
  parameter int MODE     = 0,
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_valid,
  output logic       timeout
);

  localparam logic HOLD_EN = (MAX_HOLD != 0);
  localparam logic [HOLD_W-1:0] HOLD_LAST =
    HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  state_t            state_q, state_d;
  logic [3:0]        gnt_q, gnt_d;
  logic [1:0]        gnt_id_q, gnt_id_d;
  logic              gnt_valid_q, gnt_valid_d;
  logic              timeout_q, timeout_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;

  logic [3:0] rot_req;
  logic [1:0] enc_idx;
  logic       enc_vld;
  logic [1:0] win_id;
  logic       owner_req;
  logic       hold_hit;

  assign rot_req = rot4(req, ptr_q);

  prio_enc4 u_enc (
    .in_i    (rot_req),
    .idx_o   (enc_idx),
    .valid_o (enc_vld)
  );

  // Undo the rotation to get the real client index.
  assign win_id    = enc_idx + ptr_q;
  assign owner_req = req[gnt_id_q];
  assign hold_hit  = HOLD_EN && (cnt_q == HOLD_LAST);

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_id_d    = gnt_id_q;
    gnt_valid_d = gnt_valid_q;
    timeout_d   = 1'b0;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (enc_vld) begin
          state_d     = ST_GRANT;
          gnt_d       = dec4(win_id);
          gnt_id_d    = win_id;
          gnt_valid_d = 1'b1;
          cnt_d       = '0;
        end else begin
          gnt_d       = 4'b0000;
          gnt_valid_d = 1'b0;
        end
      end
      ST_GRANT: begin
        if (!owner_req || hold_hit) begin
          state_d     = ST_IDLE;
          gnt_d       = 4'b0000;
          gnt_valid_d = 1'b0;
          // Owner drop wins over a coincident limit hit.
          timeout_d   = owner_req;
          if (MODE == MODE_RR) begin
            ptr_d = gnt_id_q;
          end
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      gnt_q       <= 4'b0000;
      gnt_id_q    <= 2'd0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      ptr_q       <= 2'd0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = gnt_valid_q;
  assign timeout   = timeout_q;

endmodule
